// File: rtl/timer_countdown_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer: FSM encoding,
// BCD digit limits and the preset clamp helper.
package timer_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam int BCD_UNIT_MAX     = 9;
    localparam int BCD_TENS_MAX     = 5;
    localparam int MIN_TENS_MAX_DEF = 5;
    localparam int NUM_DIGITS       = 4;
    localparam int DIGIT_W          = 4;

    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] v,
                                                     input logic [DIGIT_W-1:0] max);
        return (v > max) ? max : v;
    endfunction

endpackage

// File: rtl/timer_countdown_bcd_digit_down.sv
// One down-counting BCD digit: clamped load, borrow-chained decrement that
// wraps 0 -> MAX and emits a borrow to the next digit.
module bcd_digit_down
    import timer_countdown_pkg::*;
#(
    parameter int MAX = BCD_UNIT_MAX
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_val_i,
    input  logic               dec_en_i,
    input  logic               borrow_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               borrow_o
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               take;

    assign take     = dec_en_i & borrow_i;
    assign borrow_o = take & (digit_q == '0);
    assign digit_o  = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = bcd_clamp(load_val_i, MAX_V);
        end else if (take) begin
            digit_d = (digit_q == '0) ? MAX_V : digit_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) digit_q <= '0;
        else         digit_q <= digit_d;
    end

endmodule

// File: rtl/timer_countdown.sv
// MM:SS BCD countdown timer on the 1 Hz domain: preset load, pause/resume,
// one-cycle done pulse and expired level at 00:00.
module timer_countdown
    import timer_countdown_pkg::*;
#(
    parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF
) (
    input  logic               clk_1hz,
    input  logic               reset,
    input  logic               load,
    input  logic               enable,
    input  logic [DIGIT_W-1:0] preset_min_tens,
    input  logic [DIGIT_W-1:0] preset_min_unit,
    input  logic [DIGIT_W-1:0] preset_sec_tens,
    input  logic [DIGIT_W-1:0] preset_sec_unit,
    output logic [DIGIT_W-1:0] sec_unit,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_unit,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               running,
    output logic               done,
    output logic               expired
);

    // Digit index 0 = sec_unit ... 3 = min_tens
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] pre, dig;
    logic [NUM_DIGITS:0]                brw;
    logic                               min_borrow_unused;
    logic                               is_zero, is_one, dec_en;

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   running_q, expired_q;

    assign pre     = {preset_min_tens, preset_min_unit, preset_sec_tens, preset_sec_unit};
    assign is_zero = (dig == '0);
    assign is_one  = (dig == {{(NUM_DIGITS*DIGIT_W-1){1'b0}}, 1'b1});
    // Zero check gates the chain, so min_tens never has to borrow.
    assign dec_en  = !load && enable && (state_q != ST_EXPIRED) && !is_zero;
    assign brw[0]  = 1'b1;
    assign min_borrow_unused = brw[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        localparam int DMAX = (i == NUM_DIGITS-1) ? MIN_TENS_MAX :
                              (i % 2 == 1)        ? BCD_TENS_MAX : BCD_UNIT_MAX;
        bcd_digit_down #(.MAX(DMAX)) u_dig (
            .clk_i      (clk_1hz),
            .rst_ni     (reset),
            .load_i     (load),
            .load_val_i (pre[i]),
            .dec_en_i   (dec_en),
            .borrow_i   (brw[i]),
            .digit_o    (dig[i]),
            .borrow_o   (brw[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PAUSED, ST_RUN: begin
                    if (enable && !is_zero) begin
                        if (is_one) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (!enable && state_q == ST_RUN) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_EXPIRED: state_d = ST_EXPIRED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1hz or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
        end
    end

    assign sec_unit = dig[0];
    assign sec_tens = dig[1];
    assign min_unit = dig[2];
    assign min_tens = dig[3];
    assign running  = running_q;
    assign done     = done_q;
    assign expired  = expired_q;

endmodule

// File: tb/tb_timer_countdown.sv
// Scoreboard bench for timer_countdown: expected outputs are queued as each
// edge is driven and popped/compared one time unit after the edge.
module tb_timer_countdown;

    logic       clk_1hz = 1'b0;
    logic       reset   = 1'b0;
    logic       load    = 1'b0;
    logic       enable  = 1'b0;
    logic [3:0] preset_min_tens = '0, preset_min_unit = '0;
    logic [3:0] preset_sec_tens = '0, preset_sec_unit = '0;
    logic [3:0] sec_unit, sec_tens, min_unit, min_tens;
    logic       running, done, expired;

    typedef struct {
        bit          ld;
        bit          en;
        logic [15:0] pre;
        logic [18:0] exp;
    } stim_t;

    logic [18:0] sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    timer_countdown #(.MIN_TENS_MAX(5)) dut (
        .clk_1hz(clk_1hz), .reset(reset), .load(load), .enable(enable),
        .preset_min_tens(preset_min_tens), .preset_min_unit(preset_min_unit),
        .preset_sec_tens(preset_sec_tens), .preset_sec_unit(preset_sec_unit),
        .sec_unit(sec_unit), .sec_tens(sec_tens), .min_unit(min_unit), .min_tens(min_tens),
        .running(running), .done(done), .expired(expired)
    );

    always #5 clk_1hz = ~clk_1hz;

    function automatic logic [18:0] mk(input int m, input int s, input bit r, input bit d, input bit e);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), r, d, e};
    endfunction

    function automatic logic [18:0] observe();
        return {min_tens, min_unit, sec_tens, sec_unit, running, done, expired};
    endfunction

    // Drives one edge's inputs, queues its expectation, and advances past the edge.
    task automatic drive(input stim_t s);
        load   = s.ld;
        enable = s.en;
        {preset_min_tens, preset_min_unit, preset_sec_tens, preset_sec_unit} = s.pre;
        sb.push_back(s.exp);
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] e, got;
        reset = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0));
        @(posedge clk_1hz); #1;
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL reset_state got=%h exp=%h", got, e); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_expiry();
        stim_t t[7];
        logic [18:0] e, got;
        t[0] = '{1, 0, 16'h0003, mk(0, 3, 0, 0, 0)};
        t[1] = '{0, 1, 16'h0000, mk(0, 2, 1, 0, 0)};
        t[2] = '{0, 1, 16'h0000, mk(0, 1, 1, 0, 0)};
        t[3] = '{0, 1, 16'h0000, mk(0, 0, 0, 1, 1)};
        t[4] = '{0, 1, 16'h0000, mk(0, 0, 0, 0, 1)};
        t[5] = '{0, 0, 16'h0000, mk(0, 0, 0, 0, 1)};
        t[6] = '{1, 1, 16'h0002, mk(0, 2, 0, 0, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL expiry_step%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_borrow();
        stim_t t[2];
        logic [18:0] e, got;
        t[0] = '{1, 0, 16'h1000, mk(10, 0, 0, 0, 0)};
        t[1] = '{0, 1, 16'h0000, mk(9, 59, 1, 0, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL borrow_step%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_pause();
        stim_t t[7];
        logic [18:0] e, got;
        t[0] = '{1, 0, 16'h0010, mk(0, 10, 0, 0, 0)};
        t[1] = '{0, 1, 16'h0000, mk(0, 9, 1, 0, 0)};
        t[2] = '{0, 1, 16'h0000, mk(0, 8, 1, 0, 0)};
        t[3] = '{0, 1, 16'h0000, mk(0, 7, 1, 0, 0)};
        t[4] = '{0, 0, 16'h0000, mk(0, 7, 0, 0, 0)};
        t[5] = '{0, 0, 16'h0000, mk(0, 7, 0, 0, 0)};
        t[6] = '{0, 1, 16'h0000, mk(0, 6, 1, 0, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL pause_step%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_clamp();
        stim_t t[2];
        logic [18:0] e, got;
        t[0] = '{1, 0, 16'h7C8F, mk(59, 59, 0, 0, 0)};
        t[1] = '{0, 1, 16'h0000, mk(59, 58, 1, 0, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL clamp_step%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_zero_and_load_priority();
        stim_t t[7];
        logic [18:0] e, got;
        t[0] = '{1, 0, 16'h0000, mk(0, 0, 0, 0, 0)};
        t[1] = '{0, 1, 16'h0000, mk(0, 0, 0, 0, 0)};
        t[2] = '{0, 1, 16'h0000, mk(0, 0, 0, 0, 0)};
        t[3] = '{0, 1, 16'h0000, mk(0, 0, 0, 0, 0)};
        t[4] = '{1, 0, 16'h0005, mk(0, 5, 0, 0, 0)};
        t[5] = '{0, 1, 16'h0000, mk(0, 4, 1, 0, 0)};
        t[6] = '{1, 1, 16'h0005, mk(0, 5, 0, 0, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL zero_load_step%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        stim_t t[5];
        logic [18:0] e, got;
        t[0] = '{1, 0, 16'h0500, mk(5, 0, 0, 0, 0)};
        t[1] = '{0, 1, 16'h0000, mk(4, 59, 1, 0, 0)};
        t[2] = '{0, 1, 16'h0000, mk(4, 58, 1, 0, 0)};
        t[3] = '{0, 1, 16'h0000, mk(4, 57, 1, 0, 0)};
        t[4] = '{0, 1, 16'h0000, mk(4, 56, 1, 0, 0)};
        foreach (t[i]) begin
            drive(t[i]);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL areset_step%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
        // Mid-cycle reset, sampled well before the next rising edge
        #2 reset = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0));
        #1;
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL areset_immediate got=%h exp=%h", got, e); else n_pass++;
        @(posedge clk_1hz); #1;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_borrow();
        test_pause();
        test_clamp();
        test_zero_and_load_priority();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
